mmio_in_ports: RTL and testbench
================================

Name: mmio_in_ports

Overview:
Memory-mapped input-port peripheral. It is the read-side counterpart of the processor's PORT_OUT_A..D store path. Four external WIDTH-bit inputs are synchronised into the clk domain and exposed as load-readable registers at BASE_ADDR+0..+3. A sticky change-status register and a maskable interrupt are also provided. It sits beside MEMORY on the data-side load/store bus; the load mux selects rd_data when rd_valid is high.

Parameters:
WIDTH, 32, data/address width
BASE_ADDR, 32'h40000000, address of PORT_IN_A; registers occupy consecutive addresses BASE_ADDR+0..+5
SYNC_STAGES, 2, synchroniser depth per input bit (legal 2..4)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
port_in_a  input  WIDTH  external input A, asynchronous to clk
port_in_b  input  WIDTH  external input B
port_in_c  input  WIDTH  external input C
port_in_d  input  WIDTH  external input D
rd_en  input  1  load request this cycle
rd_addr  input  WIDTH  load address
rd_data  output  WIDTH  load response, registered
rd_valid  output  1  rd_data holds a response for this block
wr_en  input  1  store request this cycle
wr_addr  input  WIDTH  store address
wr_data  input  WIDTH  store data
irq  output  1  level interrupt, |(changed & mask)

Behaviour:
- Reset (clock, reset): reset is synchronous and active-high; the clock is clk. On reset, all synchroniser stages, prev samples, changed[3:0], mask[3:0], rd_data and rd_valid go to 0; irq = 0.
- Register map, offset = addr - BASE_ADDR:
  - 0..3: DATA_A..D, read-only, synchronised value s_x.
  - 4: STATUS, read-to-clear, changed[3:0] (A = bit0) in bits 3:0, upper bits 0.
  - 5: MASK, read/write, mask[3:0] in bits 3:0, upper bits 0.
  - Other offsets are not decoded.
- Synchroniser: SYNC_STAGES flops per bit; s_x = last stage. An input change before edge k is visible on s_x after edge k+SYNC_STAGES-1.
- Change detect: prev_x <= s_x every cycle. When s_x != prev_x, changed[x] is set at the next edge. After reset, a nonzero input therefore flags a change; this is intended.
- Read latency is 1 cycle, matching MEMORY:
  - rd_en & hit in cycle t gives rd_valid = 1 and rd_data = register value sampled at the edge ending cycle t, both during cycle t+1.
  - No hit, or rd_en = 0: rd_valid = 0 and rd_data = 0. This keeps the data OR-mux-safe.
  - Back-to-back reads are supported, one per cycle, with no stall.
- STATUS read-to-clear:
  - The captured bits are cleared at the same edge that loads rd_data.
  - If a new change on bit x lands at that edge, changed[x] stays 1 (set wins).
- MASK write: wr_en & wr_addr == BASE_ADDR+5 sets mask <= wr_data[3:0].
  - Stores to offsets 0..4 or unmapped offsets are ignored.
  - Same-cycle read and write of MASK: the read returns the old mask.
- Access size is ignored; the full WIDTH is always returned. Address wrap is not considered; BASE_ADDR+5 must not overflow.
- irq is combinational from flops only: |(changed & mask). It deasserts the cycle after the clearing STATUS read, unless re-set by a new change.
- Reset mid-operation: a pending response is dropped (rd_valid = 0 next cycle), and all state returns to its reset values.

Decomposition:
- Shared package holds:
  - Offset constants: OFF_DATA_A=0, OFF_DATA_B=1, OFF_DATA_C=2, OFF_DATA_D=3, OFF_STATUS=4, OFF_MASK=5.
  - PORT_IN_BASE = 32'h40000000.
  - NUM_IN_PORTS = 4.
- One sub-module, in_port_sync (params WIDTH, SYNC_STAGES): synchroniser plus prev register plus change pulse, instantiated 4 times.
- Decode, STATUS/MASK registers and the read mux live in the top.

Test Plan:
- Reset is held 3 cycles with port_in_a = 0x5 -> rd_valid = 0, rd_data = 0, irq = 0. First changed[0] set exactly SYNC_STAGES+1 edges after release.
- port_in_b steps 0 -> 0xDEADBEEF at edge k; read 0x40000001 every cycle -> returns 0 until the read issued after edge k+1, then 0xDEADBEEF. rd_valid is high the cycle after each rd_en.
- Write MASK = 0x4, then toggle port_in_c -> irq rises the cycle after changed[2] sets. Read 0x40000004 -> rd_data = 0x4, and irq = 0 the following cycle.
- STATUS read coinciding with a new port_in_a change at the capture edge -> rd_data bit0 = 1 and changed[0] remains 1. A second read returns 0x1, a third returns 0x0.
- Read 0x40000006 and 0x3FFFFFFF; store 0x12345678 to 0x40000000 -> rd_valid = 0, rd_data = 0, DATA_A unchanged, mask unchanged.
- Same-cycle store MASK = 0xF and load of MASK (old 0x3) -> returns 0x3; the next read returns 0xF. Assert reset during the response cycle -> rd_valid = 0, mask = 0.

Source files
------------

// File: rtl/mmio_in_ports_pkg.sv
// Shared constants for the memory-mapped input-port peripheral.
// Register offsets are relative to the block base address.
package mmio_in_ports_pkg;

  localparam int unsigned NUM_IN_PORTS = 4;
  localparam logic [31:0] PORT_IN_BASE = 32'h4000_0000;

  localparam int unsigned OFF_DATA_A = 0;
  localparam int unsigned OFF_DATA_B = 1;
  localparam int unsigned OFF_DATA_C = 2;
  localparam int unsigned OFF_DATA_D = 3;
  localparam int unsigned OFF_STATUS = 4;
  localparam int unsigned OFF_MASK   = 5;
  localparam int unsigned NUM_REGS   = 6;

endpackage

// File: rtl/in_port_sync.sv
// Multi-flop synchroniser for one external input word, with a one-cycle-late
// copy used to flag any change of the synchronised value.
module in_port_sync #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] port_in,
  output logic [WIDTH-1:0] sync_out,
  output logic             changed
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  prev_q, prev_d;

  always_comb begin
    // stage 0 samples the raw input; higher stages shift toward sync_out
    sync_d = {sync_q[SYNC_STAGES-2:0], port_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign changed  = (sync_q[SYNC_STAGES-1] != prev_q);

endmodule

// File: rtl/mmio_in_ports.sv
// Load-readable input ports with sticky change status, interrupt mask and a
// one-cycle registered read path that drives zero when not selected.
module mmio_in_ports
  import mmio_in_ports_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR   = WIDTH'(PORT_IN_BASE),
  parameter int               SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] port_in_a,
  input  logic [WIDTH-1:0] port_in_b,
  input  logic [WIDTH-1:0] port_in_c,
  input  logic [WIDTH-1:0] port_in_d,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             irq
);

  logic [NUM_IN_PORTS-1:0][WIDTH-1:0] port_in, sync_val;
  logic [NUM_IN_PORTS-1:0]            chg;

  assign port_in = {port_in_d, port_in_c, port_in_b, port_in_a};

  for (genvar g = 0; g < NUM_IN_PORTS; g++) begin : g_port
    in_port_sync #(
      .WIDTH      (WIDTH),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .port_in (port_in[g]),
      .sync_out(sync_val[g]),
      .changed (chg[g])
    );
  end

  logic [WIDTH-1:0]        rd_off, wr_off;
  logic [NUM_IN_PORTS-1:0] changed_q, changed_d;
  logic [NUM_IN_PORTS-1:0] mask_q, mask_d;
  logic [NUM_IN_PORTS-1:0] status_clr;
  logic [WIDTH-1:0]        rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    unused_wr_hi;

  assign unused_wr_hi = ^wr_data[WIDTH-1:NUM_IN_PORTS];

  always_comb begin
    // addresses below the base wrap to huge offsets and so never decode
    rd_off     = rd_addr - BASE_ADDR;
    wr_off     = wr_addr - BASE_ADDR;
    rd_valid_d = 1'b0;
    rd_data_d  = '0;
    status_clr = '0;
    if (rd_en && (rd_off < WIDTH'(NUM_REGS))) begin
      rd_valid_d = 1'b1;
      if (rd_off < WIDTH'(NUM_IN_PORTS)) begin
        rd_data_d = sync_val[rd_off[1:0]];
      end else if (rd_off == WIDTH'(OFF_STATUS)) begin
        rd_data_d  = WIDTH'(changed_q);
        status_clr = changed_q;
      end else begin
        rd_data_d = WIDTH'(mask_q);
      end
    end
    // only the bits actually returned are cleared; a fresh change wins
    changed_d = (changed_q & ~status_clr) | chg;
    mask_d    = (wr_en && (wr_off == WIDTH'(OFF_MASK))) ?
                wr_data[NUM_IN_PORTS-1:0] : mask_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      changed_q  <= '0;
      mask_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      changed_q  <= changed_d;
      mask_q     <= mask_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = |(changed_q & mask_q);

endmodule

// File: tb/tb_mmio_in_ports.sv
// Directed bench for mmio_in_ports: inputs driven and outputs sampled on the
// falling edge, expected values written out by hand.
module tb_mmio_in_ports;

  localparam int          WIDTH = 32;
  localparam int          SS    = 2;
  localparam logic [31:0] BASE  = 32'h4000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] port_in_a, port_in_b, port_in_c, port_in_d;
  logic             rd_en;
  logic [WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             wr_en;
  logic [WIDTH-1:0] wr_addr, wr_data;
  logic             irq;

  int n_cmp = 0;
  int n_err = 0;

  mmio_in_ports #(
    .WIDTH(WIDTH), .BASE_ADDR(BASE), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset(reset),
    .port_in_a(port_in_a), .port_in_b(port_in_b),
    .port_in_c(port_in_c), .port_in_d(port_in_d),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .irq(irq)
  );

  always #5 clk = ~clk;

  // one rising edge passes; returns on the following falling edge
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; port_in_a = 32'h5; port_in_b = '0; port_in_c = '0; port_in_d = '0;
    rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();
    n_cmp++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
    n_cmp++; if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got %0b want 0", irq); end
    reset = 1'b0;
    for (int i = 1; i <= SS + 1; i++) begin
      tick();
      n_cmp++;
      if (dut.changed_q[0] !== (i == SS + 1)) begin
        n_err++; $display("FAIL first_change edge %0d got %0b want %0b", i, dut.changed_q[0], (i == SS + 1));
      end
    end
    // clear the post-reset change on A
    rd_en = 1'b1; rd_addr = BASE + 4;
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_data !== 32'h1 || rd_valid !== 1'b1) begin
      n_err++; $display("FAIL reset_status got %h/%0b want 00000001/1", rd_data, rd_valid); end
  endtask

  task automatic test_data_b();
    logic [31:0] exp;
    port_in_b = 32'hDEAD_BEEF;
    rd_en = 1'b1; rd_addr = BASE + 1;
    for (int i = 0; i < SS + 2; i++) begin
      tick();
      exp = (i >= SS) ? 32'hDEAD_BEEF : 32'h0;
      n_cmp++;
      if (rd_data !== exp || rd_valid !== 1'b1) begin
        n_err++; $display("FAIL data_b read %0d got %h/%0b want %h/1", i, rd_data, rd_valid, exp);
      end
    end
    rd_en = 1'b0;
    tick();
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_err++; $display("FAIL idle_after_read got %h/%0b want 0/0", rd_data, rd_valid); end
    rd_en = 1'b1; rd_addr = BASE + 4;
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_data !== 32'h2) begin n_err++; $display("FAIL status_b got %h want 00000002", rd_data); end
  endtask

  task automatic test_irq();
    wr_en = 1'b1; wr_addr = BASE + 5; wr_data = 32'h4;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_before got %0b want 0", irq); end
    port_in_c = 32'h1;
    for (int i = 0; i <= SS; i++) begin
      tick();
      n_cmp++;
      if (irq !== (i == SS) || dut.changed_q[2] !== (i == SS)) begin
        n_err++; $display("FAIL irq_rise edge %0d got irq %0b chg %0b want %0b", i, irq, dut.changed_q[2], (i == SS));
      end
    end
    rd_en = 1'b1; rd_addr = BASE + 4;
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_data !== 32'h4) begin n_err++; $display("FAIL status_c got %h want 00000004", rd_data); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear got %0b want 0", irq); end
  endtask

  task automatic test_status_race();
    logic [31:0] exp [3];
    exp[0] = 32'h1; exp[1] = 32'h1; exp[2] = 32'h0;
    // A: 5 -> 6 -> 7 on consecutive edges; second change lands on the read edge
    port_in_a = 32'h6;
    tick();
    port_in_a = 32'h7;
    tick();
    repeat (SS - 1) tick();
    rd_en = 1'b1; rd_addr = BASE + 4;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rd_data !== exp[i]) begin
        n_err++; $display("FAIL race_read %0d got %h want %h", i, rd_data, exp[i]);
      end
      if (i == 0) begin
        n_cmp++;
        if (dut.changed_q[0] !== 1'b1) begin n_err++; $display("FAIL race_set_wins got %0b want 1", dut.changed_q[0]); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_unmapped();
    logic [31:0] addrs [2];
    addrs[0] = BASE + 6; addrs[1] = 32'h3FFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      rd_en = 1'b1; rd_addr = addrs[i];
      tick();
      n_cmp++;
      if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
        n_err++; $display("FAIL unmapped %h got %h/%0b want 0/0", addrs[i], rd_data, rd_valid);
      end
    end
    rd_en = 1'b0;
    wr_en = 1'b1; wr_addr = BASE; wr_data = 32'h1234_5678;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = BASE;
    tick();
    n_cmp++; if (rd_data !== 32'h7) begin n_err++; $display("FAIL data_a_ro got %h want 00000007", rd_data); end
    rd_addr = BASE + 5;
    tick();
    rd_en = 1'b0;
    n_cmp++; if (rd_data !== 32'h4) begin n_err++; $display("FAIL mask_kept got %h want 00000004", rd_data); end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_addr = BASE + 5; wr_data = 32'h3;
    tick();
    wr_data = 32'hF;
    rd_en = 1'b1; rd_addr = BASE + 5;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (rd_data !== 32'h3 || rd_valid !== 1'b1) begin
      n_err++; $display("FAIL mask_old got %h/%0b want 00000003/1", rd_data, rd_valid); end
    tick();
    n_cmp++; if (rd_data !== 32'hF || rd_valid !== 1'b1) begin
      n_err++; $display("FAIL mask_new got %h/%0b want 0000000f/1", rd_data, rd_valid); end
    // response cycle of a read is cut short by reset
    reset = 1'b1;
    tick();
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'h0) begin
      n_err++; $display("FAIL reset_drop got %h/%0b want 0/0", rd_data, rd_valid); end
    n_cmp++; if (dut.mask_q !== 4'h0 || irq !== 1'b0) begin
      n_err++; $display("FAIL reset_mask got %h/%0b want 0/0", dut.mask_q, irq); end
    rd_en = 1'b0; reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_data_b();
    test_irq();
    test_status_race();
    test_unmapped();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
